// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - signed value to 4-digit multiplexed 7-segment display via serial double-dabble
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros instead of showing 0).
module seg_display_driver #(
    parameter int DATA_WIDTH    = 10,
    parameter int DIV_WIDTH     = 12,
    parameter int ANODE_WIDTH   = 4,
    parameter int SEGMENT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    value,
    input  logic                     value_error,
    input  logic                     value_valid,
    output logic                     busy,
    output logic                     done,
    output logic [ANODE_WIDTH-1:0]   anodes,
    output logic [SEGMENT_WIDTH-1:0] segments
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    // Four BCD nibbles: thousands only exists to flag values above 999.
    localparam int BCD_W = 16;

    localparam logic [SEGMENT_WIDTH-1:0] G_ZERO  = SEGMENT_WIDTH'(8'hC0);
    localparam logic [SEGMENT_WIDTH-1:0] G_E     = SEGMENT_WIDTH'(8'h86);
    localparam logic [SEGMENT_WIDTH-1:0] G_MINUS = SEGMENT_WIDTH'(8'hBF);
    localparam logic [SEGMENT_WIDTH-1:0] G_BLANK = SEGMENT_WIDTH'(8'hFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_LOAD_ERR
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sign_q, sign_d;

    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pend_val_q, pend_val_d;
    logic                  pend_err_q, pend_err_d;

    logic [ANODE_WIDTH-1:0][SEGMENT_WIDTH-1:0] disp_q, disp_d;
    logic                  done_q, done_d;

    logic [DIV_WIDTH-1:0]     div_q, div_d;
    logic [1:0]               idx_q, idx_d;
    logic [ANODE_WIDTH-1:0]   anodes_q, anodes_d;
    logic [SEGMENT_WIDTH-1:0] seg_q, seg_d;

    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_val;
    logic                  src_err;
    logic                  launch;
    logic                  load_num;
    logic                  load_err;

    logic [BCD_W-1:0]         bcd_adj;
    logic [SEGMENT_WIDTH-1:0] g0, g1, g2, g3;

    function automatic logic [SEGMENT_WIDTH-1:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return SEGMENT_WIDTH'(g);
    endfunction

    // A fresh strobe always wins over an older pending one (last-wins).
    always_comb begin
        src_valid = 1'b0;
        src_val   = value;
        src_err   = value_error;
        if (value_valid) begin
            src_valid = 1'b1;
        end else if (pend_q) begin
            src_valid = 1'b1;
            src_val   = pend_val_q;
            src_err   = pend_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (src_valid) state_d = src_err ? S_LOAD_ERR : S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (src_valid) state_d = src_err ? S_LOAD_ERR : S_SHIFT;
                else           state_d = S_IDLE;
            end
            S_LOAD_ERR: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_SHIFT) || (state_q == S_LOAD);
        load_num = (state_q == S_LOAD);
        load_err = (state_q == S_LOAD_ERR);
        launch   = src_valid && ((state_q == S_IDLE) || (state_q == S_LOAD));
    end

    always_comb begin
        for (int i = 0; i < BCD_W / 4; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        g0 = glyph(bcd_q[3:0]);
        g1 = glyph(bcd_q[7:4]);
        g2 = glyph(bcd_q[11:8]);
        g3 = sign_q ? G_MINUS : G_ZERO;
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'd0) begin
            g2 = G_BLANK;
            if (bcd_q[7:4] == 4'd0) g1 = G_BLANK;
        end
        if (!sign_q) g3 = G_BLANK;
`else
        if (1'b0) g3 = G_BLANK;
`endif
    end

    always_comb begin
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_err_d = pend_err_q;
        disp_d     = disp_q;
        done_d     = load_num || load_err;

        if (load_num) begin
            if (bcd_q[15:12] != 4'd0) begin
                disp_d = {G_ZERO, G_ZERO, G_ZERO, G_E};
            end else begin
                disp_d = {g3, g2, g1, g0};
            end
        end
        if (load_err) begin
            disp_d = {G_ZERO, G_ZERO, G_ZERO, G_E};
        end

        if (state_q == S_SHIFT) begin
            bcd_d = {bcd_adj[BCD_W-2:0], mag_q[DATA_WIDTH-1]};
            mag_d = {mag_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
        end

        // Launch consumes the pending slot; otherwise a strobe lands in it.
        if (launch) begin
            pend_d = 1'b0;
            sign_d = src_val[DATA_WIDTH-1];
            mag_d  = src_val[DATA_WIDTH-1] ? (~src_val + 1'b1) : src_val;
            bcd_d  = '0;
            cnt_d  = '0;
        end else if (value_valid) begin
            pend_d     = 1'b1;
            pend_val_d = value;
            pend_err_d = value_error;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            pend_err_q <= 1'b0;
            disp_q     <= {ANODE_WIDTH{G_ZERO}};
            done_q     <= 1'b0;
        end else begin
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_err_q <= pend_err_d;
            disp_q     <= disp_d;
            done_q     <= done_d;
        end
    end

    // Anode and segment registers load from the same next index so they never disagree.
    always_comb begin
        div_d    = div_q + 1'b1;
        idx_d    = (&div_q) ? idx_q + 2'd1 : idx_q;
        anodes_d = ~(ANODE_WIDTH'(1) << idx_d);
        seg_d    = disp_q[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            idx_q    <= 2'd0;
            anodes_q <= ~ANODE_WIDTH'(1);
            seg_q    <= G_ZERO;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            anodes_q <= anodes_d;
            seg_q    <= seg_d;
        end
    end

    assign done     = done_q;
    assign anodes   = anodes_q;
    assign segments = seg_q;

endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Downstream display stage of the calculator. Takes the signed arithmetic result, or an error flag, from the compute stage.
- Converts the value to sign plus three BCD digits using a sequential double-dabble engine.
- Time-multiplexes four common-anode 7-segment digits, driving the top-level anodes/segments pins directly.

Parameters:
- DATA_WIDTH, 10, width of signed input value (two's complement); covers -15..225.
- DIV_WIDTH, 12, refresh divider width; digit advances each 2^DIV_WIDTH clocks.
- ANODE_WIDTH, 4, number of digits (fixed 4; other values unsupported).
- SEGMENT_WIDTH, 8, segment bus width, bit 7 = decimal point.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- value  in  DATA_WIDTH  signed result to display
- value_error  in  1  sampled with value_valid; 1 = show error pattern
- value_valid  in  1  single-cycle strobe: new value/error present
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when display registers update
- anodes  out  ANODE_WIDTH  active-low digit select
- segments  out  SEGMENT_WIDTH  active-low segments, bit 7 (dp) always 1

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, pending cleared, FSM=IDLE.
  - Display registers = +000.
  - Refresh counter=0, digit index=0, so anodes=4'b1110 and segments=8'b11000000.
- Glyphs (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, E=86, minus=BF, blank=FF.
- FSM IDLE:
  - value_valid=1 with value_error=1: go to LOAD_ERR.
  - value_valid=1 otherwise: capture sign = value[MSB] and magnitude = |value| (zero-extended; -2^(DATA_WIDTH-1) handled via the extra bit). Clear BCD accumulator, go to SHIFT with iteration count 0.
- SHIFT:
  - Each cycle: add-3 to any BCD nibble >= 5, then shift left by one, bringing in the magnitude MSB.
  - After DATA_WIDTH iterations go to LOAD.
  - busy=1 throughout SHIFT and LOAD.
- LOAD:
  - Thousands nibble != 0 (magnitude > 999): display = error pattern.
  - Otherwise digit0 = ones, digit1 = tens, digit2 = hundreds, digit3 = minus if sign else 0.
  - Pulse done. Go to IDLE, or straight to SHIFT if a pending value exists.
- LOAD_ERR: one cycle. Display = digit0 E, digits1-3 = 0. Pulse done, then IDLE.
- Latency: value_valid sampled at edge 0 gives display update and done at edge DATA_WIDTH+1 (edge 1 for error).
- value_valid while busy: store in a single pending slot, last-wins overwrite. No strobe is dropped silently other than by overwrite. Pending starts immediately after LOAD.
- value_valid coincident with LOAD: treated as pending.
- Display registers change only in LOAD/LOAD_ERR. The scan never shows a partially converted value.
- Scan:
  - Free-running DIV_WIDTH counter. On wrap (all ones to 0), digit index increments mod 4.
  - anodes sequence: 1110 → 1101 → 1011 → 0111 → 1110 …, exactly one anode low at all times.
  - segments registered with anodes, same edge, so there is no cross-digit glitch.
  - Scan is independent of conversion activity.
- Reset mid-conversion: everything returns to reset values immediately. The pending slot is lost.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Positive values: leading-zero digits above the most significant nonzero digit show blank (FF). Value 0 shows one 0 in digit0.
  - Negative values: minus stays in digit3, intervening leading zeros blank.
  - Error pattern unchanged.
- Undefined: all digits always show numerals as specified (digit3 = 0 for non-negative).

Test Plan:
- Reset release, no strobes → anodes cycles 1110,1101,1011,0111 with each held exactly 4096 clocks; segments = C0 on every digit.
- value=225 strobe → done at edge 11, busy high for edges 1-11. Scan shows digit0=92, digit1=A4, digit2=A4, digit3=C0.
- value=-15 strobe → digit0=92, digit1=F9, digit2=C0, digit3=BF.
- value_error=1 strobe → done next edge; digit0=86, others C0. With LEADING_ZERO_BLANK_EN, 7 shows FF,FF,FF,F8 on digits 3..0.
- Strobe 12, then 34 and 56 strobed while busy → exactly two done pulses; final display 056, the 34 overwritten.
- rst_n low during SHIFT of 200 → outputs immediately reset (1110/C0). The following strobe of 9 converts normally.
